// File: rtl/sr_reg_bank.sv
// sr_reg_bank: WIDTH-bit bank of clocked SR flip-flops with selectable
// S=R=1 handling, per-bit edge pulses and conflict diagnostics.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   en              update enable; 0 = bank holds and s/r are ignored
//   s, r            per-bit set / reset requests
//   clr_err         clears conflict_sticky and conflict_cnt
//   q, qn           flop state and its registered complement
//   rise, fall      one-cycle pulses when a bit changed 0->1 / 1->0
//   conflict        any bit had s=r=1 with en=1 on the previous edge
//   conflict_sticky set by any conflict, held until clr_err/reset
//   conflict_cnt    saturating count of conflict cycles

// One SR bit: state, complement and edge pulses, all registered.
module sr_reg_bit #(
    parameter int   CONFLICT_MODE = 0,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn,
    output logic rise,
    output logic fall
);
    logic q_nxt;

    always_comb begin
        q_nxt = q;
        if (en) begin
            case ({s, r})
                2'b10: q_nxt = 1'b1;
                2'b01: q_nxt = 1'b0;
                2'b11: begin
                    case (CONFLICT_MODE)
                        1:       q_nxt = 1'b1;
                        2:       q_nxt = 1'b0;
                        3:       q_nxt = ~q;
                        default: q_nxt = q;
                    endcase
                end
                default: q_nxt = q;
            endcase
        end
    end

    // Pulses come from the old/new state pair, so a hold (en=0 or a set on
    // an already-set bit) naturally yields no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= RESET_VAL;
            qn   <= ~RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            q    <= q_nxt;
            qn   <= ~q_nxt;
            rise <= ~q & q_nxt;
            fall <= q & ~q_nxt;
        end
    end
endmodule

module sr_reg_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);
    generate
        if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
            $error("sr_reg_bank: CONFLICT_MODE must be 0..3");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_reg_bit #(
            .CONFLICT_MODE(CONFLICT_MODE),
            .RESET_VAL    (RESET_VAL[i])
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .en   (en),
            .s    (s[i]),
            .r    (r[i]),
            .q    (q[i]),
            .qn   (qn[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // One event per cycle, however many bits collide.
    logic evt;
    assign evt = en & (|(s & r));

    // clr_err is applied before the same-edge event, so a colliding event
    // leaves sticky=1 and cnt=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            conflict <= evt;
            if (clr_err) begin
                conflict_sticky <= evt;
                conflict_cnt    <= evt ? CNT_ONE : '0;
            end else if (evt) begin
                conflict_sticky <= 1'b1;
                if (conflict_cnt != '1)
                    conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;
    localparam int N = 5;   // duts 0..3: modes 0..3, dut 4: mode 0 with RESET_VAL=A5

    logic       clk = 1'b0;
    logic       reset, en, clr_err;
    logic [7:0] s, r;

    logic [7:0] q_o [N];
    logic [7:0] qn_o [N];
    logic [7:0] rise_o [N];
    logic [7:0] fall_o [N];
    logic       conf_o [N];
    logic       stk_o [N];
    logic [3:0] cnt_o [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        sr_reg_bank #(
            .WIDTH(8),
            .CONFLICT_MODE(k % 4),
            .RESET_VAL((k == 4) ? 8'hA5 : 8'h00),
            .CNT_W(4)
        ) u_dut (
            .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_err(clr_err),
            .q(q_o[k]), .qn(qn_o[k]), .rise(rise_o[k]), .fall(fall_o[k]),
            .conflict(conf_o[k]), .conflict_sticky(stk_o[k]), .conflict_cnt(cnt_o[k])
        );
    end

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] q, qn, rise, fall;
        logic       conf, stk;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mq [N];
    logic       ms [N];
    logic [3:0] mc [N];

    int vectors = 0;
    int miscompares = 0;

    function automatic int mode_of(input int k);
        return k % 4;
    endfunction

    function automatic logic [7:0] rv_of(input int k);
        return (k == 4) ? 8'hA5 : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push model expectations, clock, then pop and compare.
    task automatic apply(input logic rst, input logic e, input logic [7:0] sv,
                         input logic [7:0] rv, input logic c);
        reset = rst; en = e; s = sv; r = rv; clr_err = c;
        for (int k = 0; k < N; k++) begin
            exp_t x;
            logic [7:0] nq;
            logic evt;
            x.idx = 3'(k);
            if (rst) begin
                nq = rv_of(k);
                x.rise = 8'h00; x.fall = 8'h00; x.conf = 1'b0;
                ms[k] = 1'b0; mc[k] = 4'd0;
            end else begin
                nq = mq[k];
                evt = e && ((sv & rv) != 8'h00);
                if (e) begin
                    for (int b = 0; b < 8; b++) begin
                        if (sv[b] && !rv[b]) nq[b] = 1'b1;
                        else if (!sv[b] && rv[b]) nq[b] = 1'b0;
                        else if (sv[b] && rv[b]) begin
                            if (mode_of(k) == 1) nq[b] = 1'b1;
                            else if (mode_of(k) == 2) nq[b] = 1'b0;
                            else if (mode_of(k) == 3) nq[b] = ~mq[k][b];
                        end
                    end
                end
                x.rise = ~mq[k] & nq;
                x.fall = mq[k] & ~nq;
                x.conf = evt;
                if (c) begin
                    ms[k] = evt;
                    mc[k] = evt ? 4'd1 : 4'd0;
                end else if (evt) begin
                    ms[k] = 1'b1;
                    if (mc[k] != 4'hF) mc[k] = mc[k] + 4'd1;
                end
            end
            mq[k] = nq;
            x.q = nq; x.qn = ~nq; x.stk = ms[k]; x.cnt = mc[k];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            int k;
            x = sb.pop_front();
            k = int'(x.idx);
            check($sformatf("d%0d.q", k),    q_o[k],    x.q);
            check($sformatf("d%0d.qn", k),   qn_o[k],   x.qn);
            check($sformatf("d%0d.rise", k), rise_o[k], x.rise);
            check($sformatf("d%0d.fall", k), fall_o[k], x.fall);
            check($sformatf("d%0d.conf", k), {7'd0, conf_o[k]}, {7'd0, x.conf});
            check($sformatf("d%0d.stk", k),  {7'd0, stk_o[k]},  {7'd0, x.stk});
            check($sformatf("d%0d.cnt", k),  {4'd0, cnt_o[k]},  {4'd0, x.cnt});
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; s = '0; r = '0; clr_err = 1'b0;
        for (int k = 0; k < N; k++) begin
            mq[k] = '0; ms[k] = 1'b0; mc[k] = '0;
        end
        @(negedge clk);

        // reset state
        apply(1, 0, 8'h00, 8'h00, 0);
        apply(1, 0, 8'h00, 8'h00, 0);
        check("rst.q",    q_o[0],  8'h00);
        check("rst.qn",   qn_o[0], 8'hFF);
        check("rst_a5.q", q_o[4],  8'hA5);
        check("rst_a5.qn", qn_o[4], 8'h5A);

        // set, clear, hold
        apply(0, 1, 8'h0F, 8'h00, 0);
        check("set.rise", rise_o[0], 8'h0F);
        apply(0, 1, 8'h00, 8'h03, 0);
        check("clr.fall", fall_o[0], 8'h03);
        apply(0, 1, 8'h00, 8'h00, 0);
        check("hold.q", q_o[0], 8'h0C);

        // conflict per mode
        apply(0, 1, 8'h0C, 8'h0C, 0);
        check("m0.q", q_o[0], 8'h0C);
        check("m1.q", q_o[1], 8'h0C);
        check("m2.q", q_o[2], 8'h00);
        check("m3.q", q_o[3], 8'h00);
        check("m0.cnt", {4'd0, cnt_o[0]}, 8'h01);
        apply(0, 1, 8'h00, 8'h00, 0);
        check("conf.drop", {7'd0, conf_o[0]}, 8'h00);

        // en=0 ignores s/r
        for (int i = 0; i < 3; i++) apply(0, 0, 8'hFF, 8'hFF, 0);

        // saturation and clr_err
        for (int i = 0; i < 20; i++) apply(0, 1, 8'h01, 8'h01, 0);
        check("sat.cnt", {4'd0, cnt_o[1]}, 8'h0F);
        apply(0, 1, 8'h01, 8'h01, 1);
        check("clr_evt.cnt", {4'd0, cnt_o[1]}, 8'h01);
        apply(0, 1, 8'h00, 8'h00, 1);
        check("clr.cnt", {4'd0, cnt_o[1]}, 8'h00);

        // reset mid-operation
        apply(0, 1, 8'hFF, 8'h00, 0);
        apply(1, 1, 8'hFF, 8'h00, 1);
        check("mrst.q",    q_o[4],    8'hA5);
        check("mrst.fall", fall_o[0], 8'h00);

        // random traffic
        for (int i = 0; i < 40; i++)
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
